// File: rtl/audio_udp_rx_packer.sv
// -----------------------------------------------------------------------------
// audio_udp_rx_packer
//   eth_rx_clk-domain stage between the UDP receive layer and the audio cache
//   RX controller. It filters each UDP payload on destination port and a
//   4-byte audio header, then packs the PCM payload big-endian into 32-bit
//   words for the async audio FIFO write side.
//
//   Optional feature macro: AUD_SEQ_CHECK_EN
//     When it is defined, sequence-gap tracking drives lost_cnt.
//     When it is not defined, lost_cnt is tied to zero.
//
// Ports
//   eth_rx_clk       in   Ethernet receive clock
//   rst_n            in   async reset, active-low
//   udp_rx_start     in   first payload byte marker (with udp_rx_en)
//   udp_rx_end       in   last payload byte marker (with udp_rx_en)
//   udp_rx_en        in   payload byte valid
//   udp_rx_data      in   payload byte
//   udp_rx_dst_port  in   UDP destination port, stable during a packet
//   rec_en           out  packed word valid (1 cycle)
//   rec_data         out  packed word, first byte in [31:24]
//   rec_pkt_done     out  accepted packet complete (1 cycle)
//   drop_cnt         out  dropped packet count, saturating
//   trunc_flag       out  sticky: a packet exceeded MAX_WORDS
//   lost_cnt         out  sequence-gap count, saturating
// -----------------------------------------------------------------------------
module audio_udp_rx_packer #(
    parameter logic [15:0] AUD_PORT  = 16'd1234,
    parameter logic [15:0] MAGIC     = 16'h5AA5,
    parameter int          MAX_WORDS = 256
) (
    input  logic        eth_rx_clk,
    input  logic        rst_n,
    input  logic        udp_rx_start,
    input  logic        udp_rx_end,
    input  logic        udp_rx_en,
    input  logic [7:0]  udp_rx_data,
    input  logic [15:0] udp_rx_dst_port,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] drop_cnt,
    output logic        trunc_flag,
    output logic [15:0] lost_cnt
);

    localparam int WC_W = $clog2(MAX_WORDS + 1);
    localparam logic [WC_W-1:0] MAX_WC = WC_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [1:0]        byte_cnt_r, byte_cnt_nxt_s;
    logic [23:0]       packer_r, packer_nxt_s;
    logic [WC_W-1:0]   word_cnt_r, word_cnt_nxt_s;
    logic              rec_en_r, rec_en_nxt_s;
    logic [31:0]       rec_data_r, rec_data_nxt_s;
    logic              rec_pkt_done_r, rec_pkt_done_nxt_s;
    logic [15:0]       drop_cnt_r, drop_cnt_nxt_s;
    logic              trunc_flag_r, trunc_flag_nxt_s;
    logic [1:0]        drop_inc_s;
    logic [16:0]       drop_sum_s;
    logic              emit_s;
    logic [31:0]       emit_word_s;
    logic [31:0]       shift_s;
    logic              start_v_s, end_v_s, port_ok_s, magic_ok_s, hdr_last_s;

    assign start_v_s  = udp_rx_start & udp_rx_en;
    assign end_v_s    = udp_rx_end & udp_rx_en;
    assign port_ok_s  = (udp_rx_dst_port == AUD_PORT);
    // The packer holds header bytes 0..2 when byte 3 arrives.
    assign magic_ok_s = (packer_r[23:8] == MAGIC);
    assign hdr_last_s = (byte_cnt_r == 2'd3);
    assign shift_s    = {packer_r, udp_rx_data};

    // FSM state register
    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a start byte always restarts from the IDLE decision
    always_comb begin
        state_nxt_s = state_r;
        if (start_v_s) begin
            if (end_v_s) begin
                state_nxt_s = ST_IDLE;
            end else if (port_ok_s) begin
                state_nxt_s = ST_HDR;
            end else begin
                state_nxt_s = ST_DROP;
            end
        end else if (udp_rx_en) begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_HDR: begin
                    if (end_v_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (hdr_last_s) begin
                        state_nxt_s = magic_ok_s ? ST_DATA : ST_DROP;
                    end else begin
                        state_nxt_s = ST_HDR;
                    end
                end
                ST_DATA: state_nxt_s = end_v_s ? ST_IDLE : ST_DATA;
                ST_DROP: state_nxt_s = end_v_s ? ST_IDLE : ST_DROP;
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM output / datapath next values (all outputs are registered)
    always_comb begin
        byte_cnt_nxt_s     = byte_cnt_r;
        packer_nxt_s       = packer_r;
        word_cnt_nxt_s     = word_cnt_r;
        rec_en_nxt_s       = 1'b0;
        rec_data_nxt_s     = rec_data_r;
        rec_pkt_done_nxt_s = 1'b0;
        trunc_flag_nxt_s   = trunc_flag_r;
        drop_inc_s         = 2'd0;
        emit_s             = 1'b0;
        emit_word_s        = 32'd0;
        if (start_v_s) begin
            // An unfinished packet is aborted (+1); a 1-byte packet is short (+1).
            drop_inc_s     = {1'b0, (state_r != ST_IDLE)} + {1'b0, end_v_s};
            packer_nxt_s   = shift_s[23:0];
            byte_cnt_nxt_s = 2'd1;
            word_cnt_nxt_s = '0;
        end else if (udp_rx_en) begin
            case (state_r)
                ST_IDLE: byte_cnt_nxt_s = byte_cnt_r;
                ST_HDR: begin
                    packer_nxt_s       = shift_s[23:0];
                    // Wraps to 0 after byte 3, which is the DATA starting point.
                    byte_cnt_nxt_s     = byte_cnt_r + 2'd1;
                    rec_pkt_done_nxt_s = end_v_s & hdr_last_s & magic_ok_s;
                    drop_inc_s         = (end_v_s & ~(hdr_last_s & magic_ok_s)) ? 2'd1 : 2'd0;
                end
                ST_DATA: begin
                    packer_nxt_s       = shift_s[23:0];
                    byte_cnt_nxt_s     = byte_cnt_r + 2'd1;
                    rec_pkt_done_nxt_s = end_v_s;
                    emit_s             = hdr_last_s | end_v_s;
                    // A partial final word keeps its bytes on top, zero below.
                    case (byte_cnt_r)
                        2'd0:    emit_word_s = {udp_rx_data, 24'd0};
                        2'd1:    emit_word_s = {packer_r[7:0], udp_rx_data, 16'd0};
                        2'd2:    emit_word_s = {packer_r[15:0], udp_rx_data, 8'd0};
                        default: emit_word_s = shift_s;
                    endcase
                end
                ST_DROP: drop_inc_s = end_v_s ? 2'd1 : 2'd0;
                default: byte_cnt_nxt_s = 2'd0;
            endcase
        end else begin
            packer_nxt_s = packer_r;
        end

        // Words beyond MAX_WORDS are discarded and flagged.
        if (emit_s && (word_cnt_r < MAX_WC)) begin
            rec_en_nxt_s   = 1'b1;
            rec_data_nxt_s = emit_word_s;
            word_cnt_nxt_s = word_cnt_r + WC_W'(1);
        end else if (emit_s) begin
            trunc_flag_nxt_s = 1'b1;
        end else begin
            trunc_flag_nxt_s = trunc_flag_r;
        end

        drop_sum_s     = {1'b0, drop_cnt_r} + {15'd0, drop_inc_s};
        drop_cnt_nxt_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end

    // Datapath and output registers
    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r     <= 2'd0;
            packer_r       <= 24'd0;
            word_cnt_r     <= '0;
            rec_en_r       <= 1'b0;
            rec_data_r     <= 32'd0;
            rec_pkt_done_r <= 1'b0;
            drop_cnt_r     <= 16'd0;
            trunc_flag_r   <= 1'b0;
        end else begin
            byte_cnt_r     <= byte_cnt_nxt_s;
            packer_r       <= packer_nxt_s;
            word_cnt_r     <= word_cnt_nxt_s;
            rec_en_r       <= rec_en_nxt_s;
            rec_data_r     <= rec_data_nxt_s;
            rec_pkt_done_r <= rec_pkt_done_nxt_s;
            drop_cnt_r     <= drop_cnt_nxt_s;
            trunc_flag_r   <= trunc_flag_nxt_s;
        end
    end

    assign rec_en       = rec_en_r;
    assign rec_data     = rec_data_r;
    assign rec_pkt_done = rec_pkt_done_r;
    assign drop_cnt     = drop_cnt_r;
    assign trunc_flag   = trunc_flag_r;

`ifdef AUD_SEQ_CHECK_EN
    logic        seq_valid_r;
    logic [15:0] seq_exp_r;
    logic [15:0] lost_cnt_r;
    logic        hdr_accept_s;
    logic [15:0] seq_s;
    logic [15:0] gap_s;
    logic [16:0] lost_sum_s;

    // Header byte 3 completes a valid header: sequence number is bytes 2-3.
    assign hdr_accept_s = udp_rx_en & ~start_v_s & (state_r == ST_HDR) & hdr_last_s & magic_ok_s;
    assign seq_s        = {packer_r[7:0], udp_rx_data};
    assign gap_s        = seq_s - seq_exp_r;
    assign lost_sum_s   = {1'b0, lost_cnt_r} + {1'b0, gap_s};

    // Sequence tracking; a matching sequence adds a zero gap
    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_valid_r <= 1'b0;
            seq_exp_r   <= 16'd0;
            lost_cnt_r  <= 16'd0;
        end else if (hdr_accept_s) begin
            seq_valid_r <= 1'b1;
            seq_exp_r   <= seq_s + 16'd1;
            if (seq_valid_r) begin
                lost_cnt_r <= lost_sum_s[16] ? 16'hFFFF : lost_sum_s[15:0];
            end
        end
    end

    assign lost_cnt = lost_cnt_r;
`else
    assign lost_cnt = 16'd0;
`endif

endmodule
